conv3x3_stream: RTL and testbench

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_line_buf.sv | 42 ++++
 rtl/conv3x3_stream.sv | 222 ++++++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : conv_pkg
// Brief    : Shared kernel size, default widths and FSM states for the 3x3
//            streaming convolution block.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int KER       = 3;
    localparam int DEF_DW    = 16;
    localparam int ACC_GUARD = 4;
    localparam int DEF_ACC_W = 2*DEF_DW + ACC_GUARD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_buf
// Brief    : DEPTH-stage delay line; dout is the sample written DEPTH shifts ago.
// Revision : 1.0 - initial release
// ============================================================================
module conv_line_buf #(
    parameter int DEPTH = 9,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int            C_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [C_AW-1:0] C_LAST = C_AW'(DEPTH - 1);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [C_AW-1:0] r_ptr;

    // Circular buffer: the slot about to be overwritten holds the oldest sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (shift) begin
            r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            r_mem[r_ptr] <= din;
        end
    end

    assign dout = r_mem[r_ptr];

endmodule
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream
// Brief    : Streaming 3x3 correlation over a zero-padded square frame.
//            Build option CONV3X3_RELU_EN clamps negative sums to zero.
// Revision : 1.0 - initial release
// ============================================================================
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int IMG   = 7,
    parameter int PAD   = 1,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = 2*DW + ACC_GUARD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KER*KER*DW-1:0]   fil_in,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic signed [DW-1:0]    pix_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int SIZE = IMG + 2*PAD;
    localparam int OUT  = SIZE - 2;
    localparam int NTAP = KER*KER;
    localparam int CW   = $clog2(SIZE);

    localparam logic [CW-1:0] C_LAST = CW'(SIZE - 1);
    localparam logic [CW-1:0] C_TWO  = CW'(2);

    generate
        if (ACC_W < 2*DW + ACC_GUARD) begin : g_bad_acc_w
            $error("conv3x3_stream: ACC_W must be at least 2*DW+4");
        end
        if (IMG < 3 || IMG > 63 || (PAD != 0 && PAD != 1) || OUT < 1) begin : g_bad_geom
            $error("conv3x3_stream: IMG must be 3..63 and PAD 0 or 1");
        end
    endgenerate

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;

    logic signed [DW-1:0]    r_w       [NTAP];
    logic signed [DW-1:0]    r_win     [KER][KER];
    logic signed [DW-1:0]    w_win_nxt [KER][KER];
    logic signed [DW-1:0]    w_x;
    logic signed [DW-1:0]    w_lb1;
    logic signed [DW-1:0]    w_lb2;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_res;

    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_out_data;
    logic                    r_out_last;

    logic w_run;
    logic w_pad;
    logic w_stall;
    logic w_tick;
    logic w_last_pos;
    logic w_emit;
    logic w_launch;

    generate
        if (PAD == 0) begin : g_nopad
            assign w_pad = 1'b0;
        end else begin : g_pad
            localparam logic [CW-1:0] C_LO = CW'(PAD);
            localparam logic [CW-1:0] C_HI = CW'(PAD + IMG);
            assign w_pad = (r_row < C_LO) || (r_col < C_LO) ||
                           (r_row >= C_HI) || (r_col >= C_HI);
        end
    endgenerate

    assign w_run      = (r_state == ST_RUN);
    assign w_launch   = (r_state == ST_IDLE) && start;
    assign w_stall    = r_out_valid && !out_ready;
    assign pix_ready  = w_run && !w_pad && !w_stall;
    assign w_tick     = w_run && !w_stall && (w_pad || (pix_valid && pix_ready));
    assign w_last_pos = (r_row == C_LAST) && (r_col == C_LAST);
    assign w_emit     = w_tick && (r_row >= C_TWO) && (r_col >= C_TWO);
    assign w_x        = w_pad ? '0 : pix_data;

    // Raster walk over the padded frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_launch) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_tick) begin
            if (r_col == C_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_launch) begin
            for (int k = 0; k < NTAP; k++) begin
                r_w[k] <= fil_in[(NTAP-k)*DW-1 -: DW];
            end
        end
    end

    conv_line_buf #(
        .DEPTH (SIZE),
        .DW    (DW)
    ) u_lb_row1 (
        .clk   (clk),
        .rst   (rst),
        .shift (w_tick),
        .din   (w_x),
        .dout  (w_lb1)
    );

    conv_line_buf #(
        .DEPTH (SIZE),
        .DW    (DW)
    ) u_lb_row2 (
        .clk   (clk),
        .rst   (rst),
        .shift (w_tick),
        .din   (w_lb1),
        .dout  (w_lb2)
    );

    // Window as it will look after this tick; the result is taken from it directly.
    always_comb begin
        for (int i = 0; i < KER; i++) begin
            for (int j = 0; j < KER-1; j++) begin
                w_win_nxt[i][j] = r_win[i][j+1];
            end
        end
        w_win_nxt[0][KER-1] = w_lb2;
        w_win_nxt[1][KER-1] = w_lb1;
        w_win_nxt[2][KER-1] = w_x;
    end

    always_ff @(posedge clk) begin
        if (w_tick) begin
            for (int i = 0; i < KER; i++) begin
                for (int j = 0; j < KER; j++) begin
                    r_win[i][j] <= w_win_nxt[i][j];
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < KER; i++) begin
            for (int j = 0; j < KER; j++) begin
                w_sum = w_sum + ACC_W'(w_win_nxt[i][j]) * ACC_W'(r_w[i*KER+j]);
            end
        end
    end

`ifdef CONV3X3_RELU_EN
    assign w_res = w_sum[ACC_W-1] ? '0 : w_sum;
`else
    assign w_res = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_out_last  <= w_last_pos;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only the final result can be pending in DRAIN: the last tick needs a free output slot.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_tick && w_last_pos) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_out_valid && out_ready) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_conv3x3_stream
// Brief    : Bench for conv3x3_stream; instance 0 uses PAD=1, instance 1 PAD=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv3x3_stream;

    localparam int IMG   = 7;
    localparam int DW    = 16;
    localparam int ACC_W = 2*DW + 4;
    localparam int NPIX  = IMG*IMG;

    logic clk = 1'b0;
    logic rst;

    logic                    start_s     [2];
    logic [9*DW-1:0]         fil_s       [2];
    logic                    pix_valid_s [2];
    logic signed [DW-1:0]    pix_data_s  [2];
    logic                    out_ready_s [2];
    logic                    pix_ready_o [2];
    logic                    out_valid_o [2];
    logic signed [ACC_W-1:0] out_data_o  [2];
    logic                    out_last_o  [2];
    logic                    busy_o      [2];
    logic                    done_o      [2];

    logic signed [DW-1:0] img [NPIX];
    logic signed [DW-1:0] wts [9];

    longint exp_res    [2][64];
    int     exp_n      [2];
    int     cnt        [2];
    bit     exp_done_q [2];
    bit     prev_stall [2];
    longint prev_data  [2];
    logic   prev_last  [2];
    bit     feeding    [2];
    longint got_first  [2];
    longint got_centre [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        conv3x3_stream #(
            .IMG   (IMG),
            .PAD   ((k == 0) ? 1 : 0),
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_s[k]),
            .fil_in    (fil_s[k]),
            .pix_valid (pix_valid_s[k]),
            .pix_ready (pix_ready_o[k]),
            .pix_data  (pix_data_s[k]),
            .out_valid (out_valid_o[k]),
            .out_ready (out_ready_s[k]),
            .out_data  (out_data_o[k]),
            .out_last  (out_last_o[k]),
            .busy      (busy_o[k]),
            .done      (done_o[k])
        );
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Direct evaluation of the correlation over the zero-extended image.
    task automatic build_model(input int d);
        int pad = (d == 0) ? 1 : 0;
        int o   = IMG + 2*pad - 2;
        int n   = 0;
        for (int oy = 0; oy < o; oy++) begin
            for (int ox = 0; ox < o; ox++) begin
                longint s = 0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        int y = oy + i - pad;
                        int x = ox + j - pad;
                        if (y >= 0 && y < IMG && x >= 0 && x < IMG)
                            s += longint'(wts[3*i+j]) * longint'(img[y*IMG+x]);
                    end
                end
`ifdef CONV3X3_RELU_EN
                if (s < 0) s = 0;
`endif
                exp_res[d][n] = s;
                n++;
            end
        end
        exp_n[d] = n;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cnt[k]        = 0;
                exp_done_q[k] = 1'b0;
                prev_stall[k] = 1'b0;
            end else begin
                if (start_s[k] && !busy_o[k]) cnt[k] = 0;
                chk("done_pulse", done_o[k], exp_done_q[k]);
                exp_done_q[k] = 1'b0;
                if (prev_stall[k]) begin
                    chk("stall_valid", out_valid_o[k], 1);
                    chk("stall_data", out_data_o[k], prev_data[k]);
                    chk("stall_last", out_last_o[k], prev_last[k]);
                end
                if (out_valid_o[k] && !out_ready_s[k])
                    chk("stall_no_tick", pix_ready_o[k], 0);
                if (out_valid_o[k] && out_ready_s[k]) begin
                    if (cnt[k] >= exp_n[k]) begin
                        chk("extra_result", cnt[k], exp_n[k] - 1);
                    end else begin
                        chk("out_data", out_data_o[k], exp_res[k][cnt[k]]);
                        chk("out_last", out_last_o[k], (cnt[k] == exp_n[k] - 1) ? 1 : 0);
                        if (cnt[k] == 0)  got_first[k]  = out_data_o[k];
                        if (cnt[k] == 24) got_centre[k] = out_data_o[k];
                        if (cnt[k] == exp_n[k] - 1) exp_done_q[k] = 1'b1;
                        cnt[k]++;
                    end
                end
                if (k == 1 && feeding[k] && pix_valid_s[k] && !(out_valid_o[k] && !out_ready_s[k]))
                    chk("pad0_pix_ready", pix_ready_o[k], 1);
                prev_stall[k] = out_valid_o[k] && !out_ready_s[k];
                prev_data[k]  = out_data_o[k];
                prev_last[k]  = out_last_o[k];
            end
        end
    end

    task automatic start_frame(input int d, input int mode);
        @(posedge clk); #1;
        for (int k = 0; k < 9; k++) fil_s[d][(8-k)*DW +: DW] = wts[k];
        start_s[d]     = 1'b1;
        out_ready_s[d] = (mode != 2);
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        chk("busy_after_start", busy_o[d], 1);
    endtask

    task automatic feed_pixels(input int d, input int n, input bit rv);
        int idx = 0;
        bit pv;
        bit acc;
        feeding[d] = 1'b1;
        for (int g = 0; g < 4000 && idx < n; g++) begin
            pv = rv ? ($urandom_range(0, 1) == 1) : 1'b1;
            pix_valid_s[d] = pv;
            pix_data_s[d]  = pv ? img[idx] : DW'($urandom);
            @(negedge clk);
            acc = pv && pix_ready_o[d];
            @(posedge clk); #1;
            if (acc) idx++;
        end
        pix_valid_s[d] = 1'b0;
        feeding[d]     = 1'b0;
        if (idx < n) chk("feed_timeout", idx, n);
    endtask

    // mode 0: always ready, 1: random ready, 2: five stall cycles at the first result
    task automatic drive_ready(input int d, input int mode);
        int held = 0;
        bit fin  = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(posedge clk); #1;
            case (mode)
                0:       out_ready_s[d] = 1'b1;
                1:       out_ready_s[d] = ($urandom_range(0, 3) != 0);
                default: out_ready_s[d] = (held >= 5);
            endcase
            @(negedge clk);
            if (mode == 2 && held < 5 && out_valid_o[d] && !out_ready_s[d]) begin
                chk("hold_data", out_data_o[d], 134);
                held++;
            end
            if (done_o[d]) fin = 1'b1;
        end
        if (!fin) chk("done_timeout", 0, 1);
    endtask

    task automatic poke_start(input int d);
        repeat (30) @(posedge clk);
        #1;
        start_s[d] = 1'b1;
        fil_s[d]   = ~fil_s[d];
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        fil_s[d]   = ~fil_s[d];
    endtask

    task automatic run_frame(input int d, input bit rv, input int mode, input bit poke);
        build_model(d);
        got_first[d]  = -1;
        got_centre[d] = -1;
        start_frame(d, mode);
        fork
            feed_pixels(d, NPIX, rv);
            drive_ready(d, mode);
            begin
                if (poke) poke_start(d);
            end
        join
        chk("result_count", cnt[d], exp_n[d]);
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", out_valid_o[k], 0);
            chk("rst_out_data", out_data_o[k], 0);
            chk("rst_out_last", out_last_o[k], 0);
            chk("rst_pix_ready", pix_ready_o[k], 0);
            chk("rst_busy", busy_o[k], 0);
            chk("rst_done", done_o[k], 0);
        end
    endtask

    task automatic load_ramp(input int wval_mode);
        for (int i = 0; i < NPIX; i++) img[i] = DW'(i);
        for (int k = 0; k < 9; k++) wts[k] = (wval_mode == 0) ? DW'(k + 1) : -16'sd1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; fil_s[k] = '0; pix_valid_s[k] = 1'b0;
            pix_data_s[k] = '0; out_ready_s[k] = 1'b0; feeding[k] = 1'b0;
            exp_n[k] = 0; cnt[k] = 0; exp_done_q[k] = 1'b0; prev_stall[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Ramp image, weights 1..9, padded instance
        load_ramp(0);
        run_frame(0, 1'b0, 0, 1'b0);
        chk("p1_first", got_first[0], 134);
        chk("p1_centre", got_centre[0], 1212);

        // Same data, unpadded instance
        run_frame(1, 1'b0, 0, 1'b0);
        chk("p0_first", got_first[1], 492);

        // Output stall at the first result
        run_frame(0, 1'b0, 2, 1'b0);
        chk("stall_first", got_first[0], 134);

        // Negative weights
        load_ramp(1);
        run_frame(1, 1'b0, 0, 1'b0);
`ifdef CONV3X3_RELU_EN
        chk("neg_first", got_first[1], 0);
`else
        chk("neg_first", got_first[1], -72);
`endif

        // Reset after 20 pixels, then a clean frame
        load_ramp(0);
        build_model(0);
        start_frame(0, 0);
        feed_pixels(0, 20, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs();
        rst = 1'b0;
        run_frame(0, 1'b0, 0, 1'b0);
        chk("rst_frame_first", got_first[0], 134);
        chk("rst_frame_centre", got_centre[0], 1212);

        // Pixels offered while idle, start poked mid-frame, random valid/ready
        @(posedge clk); #1;
        pix_valid_s[0] = 1'b1;
        pix_data_s[0]  = 16'sd123;
        repeat (3) begin
            @(negedge clk);
            chk("idle_pix_ready", pix_ready_o[0], 0);
        end
        @(posedge clk); #1;
        pix_valid_s[0] = 1'b0;
        run_frame(0, 1'b1, 1, 1'b1);
        chk("poke_first", got_first[0], 134);
        chk("poke_centre", got_centre[0], 1212);

        // Random full-range data on both instances
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom);
                for (int k = 0; k < 9; k++) wts[k] = DW'($urandom);
                run_frame(d, 1'b1, 1, 1'b0);
            end
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
